// File: rtl/fracn_div_ctrl_pkg.sv
// fracn_div_ctrl_pkg: shared constants and FSM encoding for the fractional-N ratio scheduler
package fracn_div_ctrl_pkg;
  localparam int FRAC_W = 8;
  localparam logic [2:0] M_MIN = 3'd1;
  localparam logic [2:0] M_MAX = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_e;
endpackage

// File: rtl/fracn_div_ctrl_acc.sv
// fracn_acc: first-order phase accumulator; carry marks the periods that need M+1
module fracn_acc #(
  parameter int FRAC_W = fracn_div_ctrl_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;
  // carry is combinational so the same edge can load cur_int + carry into the divider
  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac};
    carry = sum[FRAC_W];
    acc_d = clr ? '0 : step ? sum[FRAC_W-1:0] : acc_q;
  end
  // accumulator register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
endmodule

// File: rtl/fracn_div_ctrl.sv
// fracn_div_ctrl: issues the per-period divider ratio so the average ratio is INT + FRAC/2^FRAC_W
module fracn_div_ctrl #(
  parameter int         FRAC_W    = fracn_div_ctrl_pkg::FRAC_W,
  parameter logic [2:0] DEFAULT_M = 3'd2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_int,
  input  logic [FRAC_W-1:0] cfg_frac,
  output logic              cfg_err,
  input  logic              run_en,
  input  logic              div_pulse,
  output logic [2:0]        div_m,
  output logic              div_hold,
  output logic              active
);
  import fracn_div_ctrl_pkg::*;
  state_e            state_q, state_d;
  logic [2:0]        s_int_q, s_int_d, cur_int_q, cur_int_d, div_m_q, div_m_d, eff_int;
  logic [FRAC_W-1:0] s_frac_q, s_frac_d, cur_frac_q, cur_frac_d, eff_frac;
  logic              pend_q, pend_d, div_hold_q, div_hold_d, cfg_err_q, cfg_err_d;
  logic              xfer, cfg_ok, step, carry;
  assign cfg_ready = !(state_q == ST_RUN && pend_q);
  assign active    = state_q == ST_RUN;
  assign div_m     = div_m_q;
  assign div_hold  = div_hold_q;
  assign cfg_err   = cfg_err_q;
  assign xfer      = cfg_valid && cfg_ready;
  assign cfg_ok    = cfg_int >= M_MIN && (cfg_frac == '0 || cfg_int < M_MAX);
  assign step      = state_q == ST_RUN && run_en && div_pulse;
  assign eff_int   = pend_q ? s_int_q : cur_int_q;
  assign eff_frac  = pend_q ? s_frac_q : cur_frac_q;
  fracn_acc #(.FRAC_W(FRAC_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == ST_LOAD),
    .step  (step),
    .frac  (eff_frac),
    .carry (carry)
  );
  // next state: handshake into the shadow, FSM, and per-pulse ratio issue
  always_comb begin
    state_d    = state_q;
    div_m_d    = div_m_q;
    div_hold_d = div_hold_q;
    cur_int_d  = cur_int_q;
    cur_frac_d = cur_frac_q;
    pend_d     = pend_q;
    s_int_d    = xfer && cfg_ok ? cfg_int : s_int_q;
    s_frac_d   = xfer && cfg_ok ? cfg_frac : s_frac_q;
    cfg_err_d  = xfer && !cfg_ok;
    if (state_q == ST_IDLE) begin
      div_hold_d = 1'b1;
      div_m_d    = DEFAULT_M;
      if (run_en && s_int_q != '0) state_d = ST_LOAD;
    end else if (!run_en) begin
      state_d    = ST_IDLE;
      div_hold_d = 1'b1;
      div_m_d    = DEFAULT_M;
      pend_d     = 1'b0;
    end else if (state_q == ST_LOAD) begin
      state_d    = ST_RUN;
      div_hold_d = 1'b0;
      div_m_d    = s_int_q;
      cur_int_d  = s_int_q;
      cur_frac_d = s_frac_q;
      pend_d     = xfer && cfg_ok;
    end else begin
      if (div_pulse) begin
        cur_int_d  = eff_int;
        cur_frac_d = eff_frac;
        div_m_d    = eff_int + {2'b00, carry};
        pend_d     = 1'b0;
      end
      if (xfer && cfg_ok) pend_d = 1'b1;
    end
  end
  // state and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      div_m_q    <= DEFAULT_M;
      div_hold_q <= 1'b1;
      cur_int_q  <= '0;
      cur_frac_q <= '0;
      s_int_q    <= '0;
      s_frac_q   <= '0;
      pend_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_m_q    <= div_m_d;
      div_hold_q <= div_hold_d;
      cur_int_q  <= cur_int_d;
      cur_frac_q <= cur_frac_d;
      s_int_q    <= s_int_d;
      s_frac_q   <= s_frac_d;
      pend_q     <= pend_d;
      cfg_err_q  <= cfg_err_d;
    end
endmodule

// File: tb/tb_fracn_div_ctrl.sv
// tb_fracn_div_ctrl: directed + random checks of the fractional-N scheduler against an arithmetic ratio model
module tb_fracn_div_ctrl;
  logic       clk = 0, rst_n = 0, cfg_valid = 0, run_en = 0, div_pulse;
  logic [2:0] cfg_int = 0;
  logic [7:0] cfg_frac = 0;
  logic       cfg_ready, cfg_err, div_hold, active;
  logic [2:0] div_m;
  int errors = 0, checks = 0;
  int cnt = 0, cycles = 0, pulses = 0;
  int m_acc = 0, m_int = 0, m_frac = 0, s_int = 0, s_frac = 0;
  bit m_pend = 0, m_run = 0;

  always #5 clk = ~clk;

  fracn_div_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_int   (cfg_int),
    .cfg_frac  (cfg_frac),
    .cfg_err   (cfg_err),
    .run_en    (run_en),
    .div_pulse (div_pulse),
    .div_m     (div_m),
    .div_hold  (div_hold),
    .active    (active)
  );

  // programmable counter divider: one pulse every div_m clocks, held at zero by div_hold
  assign div_pulse = !div_hold && cnt == int'(div_m) - 1;
  always @(posedge clk) cnt <= (div_hold || div_pulse) ? 0 : cnt + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock; the model sees what the edge consumes and checks the issued ratio after it
  task automatic cyc();
    bit p, x, ok, rdy;
    p   = m_run && div_pulse === 1'b1;
    rdy = !(m_run && m_pend);
    x   = cfg_valid && rdy;
    ok  = cfg_int != 0 && (cfg_frac == 0 || cfg_int != 7);
    if (cfg_valid) chk("cfg_ready", cfg_ready, rdy);
    @(posedge clk); #1;
    cycles++;
    if (p) begin
      pulses++;
      if (m_pend) begin m_int = s_int; m_frac = s_frac; m_pend = 0; end
      m_acc = m_acc + m_frac;
      chk("div_m", div_m, m_int + (m_acc >= 256 ? 1 : 0));
      m_acc = m_acc % 256;
    end
    if (x && ok) begin s_int = cfg_int; s_frac = cfg_frac; if (m_run) m_pend = 1; end
    if (cfg_valid) chk("cfg_err", cfg_err, x && !ok);
  endtask

  task automatic offer(int i, int f);
    cfg_valid = 1; cfg_int = 3'(i); cfg_frac = 8'(f);
    cyc();
    cfg_valid = 0;
  endtask

  task automatic run_p(int n);
    int target;
    target = pulses + n;
    for (int g = 0; g < n * 20 && pulses < target; g++) cyc();
    if (pulses < target) chk("pulse_timeout", pulses, target);
  endtask

  task automatic start();
    run_en = 1;
    for (int i = 0; i < 10 && div_hold !== 1'b0; i++) cyc();
    chk("hold_fall", div_hold, 0);
    chk("load_m", div_m, s_int);
    chk("active_run", active, 1);
    m_run = 1; m_acc = 0; m_int = s_int; m_frac = s_frac; m_pend = 0;
  endtask

  int c0;
  initial begin
    // reset, then release with run_en low
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cyc();
    chk("rst_div_m", div_m, 2);
    chk("rst_hold", div_hold, 1);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_active", active, 0);
    chk("rst_err", cfg_err, 0);
    // integer ratio 3
    offer(3, 0);
    start();
    run_p(1);
    c0 = cycles;
    run_p(1);
    chk("period3", cycles - c0, 3);
    run_p(4);
    // 3.5: alternating 3,4 with 16 periods spanning 56 clocks
    offer(3, 8'h80);
    run_p(1);
    c0 = cycles;
    run_p(16);
    chk("span16", cycles - c0, 56);
    // rejected ratios
    offer(7, 1);
    offer(0, 0);
    run_p(2);
    // accepted ratio stays pending until the next pulse; a second offer stalls
    offer(5, 0);
    chk("ready_pend", cfg_ready, 0);
    offer(6, 0);
    run_p(1);
    run_p(3);
    // random ratios, valid and invalid, against the model
    for (int k = 0; k < 12; k++) begin
      offer($urandom_range(0, 7), $urandom_range(0, 1) != 0 ? $urandom_range(0, 255) : 0);
      run_p($urandom_range(3, 12));
    end
    // run_en drops on a pulse cycle: pulse ignored, IDLE wins
    offer(3, 8'h80);
    run_p(2);
    for (int i = 0; i < 20 && div_pulse !== 1'b1; i++) cyc();
    run_en = 0; m_run = 0; m_pend = 0;
    cyc();
    chk("stop_m", div_m, 2);
    chk("stop_hold", div_hold, 1);
    chk("stop_active", active, 0);
    // restart reloads the shadow with a fresh accumulator
    start();
    run_p(3);
    // asynchronous reset mid-run with a non-zero accumulator
    rst_n = 0;
    #1;
    chk("arst_m", div_m, 2);
    chk("arst_hold", div_hold, 1);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_active", active, 0);
    chk("arst_err", cfg_err, 0);
    m_run = 0; m_pend = 0; s_int = 0; s_frac = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (5) cyc();
    chk("noshadow_hold", div_hold, 1);
    chk("noshadow_active", active, 0);
    chk("noshadow_m", div_m, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
